sparse_intersect_n: RTL
=======================

Name: sparse_intersect_n

Overview:
N-way sparse index intersector: generalised successor of the 2-input decoder comparator in the sparse MAC datapath. Takes NUM_CH ascending-index (index, value) streams from the sparse decoders. For every index present in all channels, emits one beat carrying the common index and all NUM_CH values to the MAC. Adds what the 2-input version lacks: output backpressure, multi-channel pop, end-of-stream drain, a match counter and restart without reset.

Parameters:
NUM_CH, 2, number of input streams (legal 2..8; elaboration error otherwise)
INDEX_W, 16, index width (unsigned)
VALUE_W, 8, value width per channel
CNT_W, 16, match counter width

Ports:
mac_clk  in  1  clock
mac_rst  in  1  reset; asynchronous, active-low
dec_valid_i  in  NUM_CH  per-channel beat valid
dec_ready_o  out  NUM_CH  per-channel beat ready
dec_index_i  in  NUM_CH*INDEX_W  channel c index at [c*INDEX_W +: INDEX_W]
dec_value_i  in  NUM_CH*VALUE_W  channel c value at [c*VALUE_W +: VALUE_W]
dec_done_i  in  NUM_CH  end-of-stream marker beat; index/value ignored
out_valid_o  out  1  match beat valid
out_ready_i  in  1  match beat ready
out_index_o  out  INDEX_W  common index
out_value_o  out  NUM_CH*VALUE_W  per-channel values, same packing as input
out_finish_o  out  1  level, high in DONE
match_count_o  out  CNT_W  matches emitted since reset/restart, saturating
restart_i  in  1  synchronous pulse: abort/clear and return to FILL

Behaviour:
- State registers: head[c] = {vld, done, index, value}. States: FILL, COMPARE, EMIT, DRAIN, DONE.
- Accept[c] = dec_valid_i[c] & dec_ready_o[c]. Accepting a beat loads head[c] and sets vld.
- Reset: state FILL, all head vld/done = 0, match_count_o = 0.
- Outputs in reset/FILL with empty heads: out_valid_o = 0, out_finish_o = 0, out_index_o/out_value_o = 0, dec_ready_o = all ones.
- FILL: dec_ready_o[c] = ~head[c].vld. Go to COMPARE in the cycle after every head is valid (condition evaluated on head.vld | accept).
- COMPARE (1 cycle, dec_ready_o = 0):
  - Any head done: go to DRAIN. Clear vld of non-done heads.
  - Otherwise, all indices equal: latch out_index_o/out_value_o and go to EMIT.
  - Otherwise: compute unsigned max index and clear vld on every head whose index < max (multiple channels may pop at once). Go to FILL.
- EMIT: out_valid_o = 1; data held stable until handshake.
  - On out_ready_i: clear all head vld, match_count_o += 1 (holds at all-ones), go to FILL.
  - out_valid_o never drops without a handshake, except on restart_i.
- Minimum spacing between matches: 3 cycles (FILL, COMPARE, EMIT). First out_valid_o comes 2 cycles after the cycle in which the last needed beat is accepted.
- DRAIN:
  - dec_ready_o[c] = ~head[c].done. Accepted beats with done = 0 are discarded; a done = 1 beat sets head[c].done.
  - When all heads are done, go to DONE.
  - Channels already done in the same COMPARE cycle accept nothing more.
- DONE: out_finish_o = 1, dec_ready_o = 0, out_valid_o = 0. Remains until restart_i.
- restart_i (any state, highest priority):
  - Next cycle state = FILL; all head vld/done cleared; match_count_o = 0; out regs = 0.
  - Beats offered in the restart cycle are not accepted (dec_ready_o forced 0 that cycle).
- Upstream requirement: strictly ascending index per stream between markers. With non-ascending input the block still makes progress (each COMPARE pops or emits) but the match set is undefined.
- Equal indices with max = all ones and index 0 are handled as ordinary unsigned values.

Test Plan:
- NUM_CH=2; ch0 idx {1,4,7,done}, ch1 idx {4,5,7,done}, out_ready_i=1 -> matches idx 4 then 7 with both values; finish; match_count_o=2.
- NUM_CH=3; idx ch0 {2,9}, ch1 {3,9}, ch2 {9} -> first COMPARE pops ch0 and ch1 in the same cycle; single match idx 9 with values in packed order.
- Backpressure: match pending, out_ready_i low for 5 cycles -> out_valid_o high, data stable, dec_ready_o all 0, count unchanged until handshake.
- Early done: ch0 done after 1 beat, ch1 sends 4 more beats then done -> DRAIN accepts and discards the 4 beats, no out_valid_o, out_finish_o rises the cycle after ch1 done.
- restart_i during EMIT with count=3 -> next cycle out_valid_o=0, state FILL, match_count_o=0, dec_ready_o all ones; new streams process correctly.
- Saturation with CNT_W=2: 5 matches -> match_count_o reads 1,2,3,3,3.

Source files
------------

// File: rtl/sparse_intersect_n_if.sv
// rtl/sparse_intersect_n_if.sv - decoder-to-MAC bundle for the N-way sparse index intersector
interface sparse_intersect_n_if #(
  parameter int NUM_CH  = 2,
  parameter int INDEX_W = 16,
  parameter int VALUE_W = 8,
  parameter int CNT_W   = 16
);
  logic [NUM_CH-1:0]         dec_valid_i;
  logic [NUM_CH-1:0]         dec_ready_o;
  logic [NUM_CH*INDEX_W-1:0] dec_index_i;
  logic [NUM_CH*VALUE_W-1:0] dec_value_i;
  logic [NUM_CH-1:0]         dec_done_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [INDEX_W-1:0]        out_index_o;
  logic [NUM_CH*VALUE_W-1:0] out_value_o;
  logic                      out_finish_o;
  logic [CNT_W-1:0]          match_count_o;
  logic                      restart_i;

  modport slave (
    input  dec_valid_i, dec_index_i, dec_value_i, dec_done_i, out_ready_i, restart_i,
    output dec_ready_o, out_valid_o, out_index_o, out_value_o, out_finish_o, match_count_o
  );

  modport master (
    output dec_valid_i, dec_index_i, dec_value_i, dec_done_i, out_ready_i, restart_i,
    input  dec_ready_o, out_valid_o, out_index_o, out_value_o, out_finish_o, match_count_o
  );
endinterface

// File: rtl/sparse_intersect_n.sv
// rtl/sparse_intersect_n.sv - N-way ascending-index stream intersector feeding the sparse MAC
module sparse_intersect_n #(
  parameter int NUM_CH  = 2,
  parameter int INDEX_W = 16,
  parameter int VALUE_W = 8,
  parameter int CNT_W   = 16
) (
  input logic                 mac_clk,
  input logic                 mac_rst,
  sparse_intersect_n_if.slave bus
);

  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("sparse_intersect_n: NUM_CH must be within 2..8");
  end

  typedef enum logic [2:0] {S_FILL, S_COMPARE, S_EMIT, S_DRAIN, S_DONE} state_t;

  state_t                    state;
  logic [NUM_CH-1:0]         head_vld;
  logic [NUM_CH-1:0]         head_done;
  logic [INDEX_W-1:0]        head_index [NUM_CH];
  logic [VALUE_W-1:0]        head_value [NUM_CH];

  logic                      out_valid_q;
  logic                      out_finish_q;
  logic [INDEX_W-1:0]        out_index_q;
  logic [NUM_CH*VALUE_W-1:0] out_value_q;
  logic [CNT_W-1:0]          count_q;

  logic [NUM_CH-1:0]         dec_ready;
  logic [NUM_CH-1:0]         accept;
  logic [INDEX_W-1:0]        max_index;
  logic                      all_equal;
  logic                      any_done;
  logic [NUM_CH*VALUE_W-1:0] values_packed;

  // A restart cycle refuses every beat so nothing leaks into the fresh run.
  always_comb begin
    dec_ready = '0;
    if (!bus.restart_i) begin
      case (state)
        S_FILL:  dec_ready = ~head_vld;
        S_DRAIN: dec_ready = ~head_done;
        default: dec_ready = '0;
      endcase
    end
  end

  assign accept   = bus.dec_valid_i & dec_ready;
  assign any_done = |head_done;

  always_comb begin
    max_index     = head_index[0];
    all_equal     = 1'b1;
    values_packed = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (head_index[c] > max_index) max_index = head_index[c];
      if (head_index[c] != head_index[0]) all_equal = 1'b0;
      values_packed[c*VALUE_W +: VALUE_W] = head_value[c];
    end
  end

  always_ff @(posedge mac_clk or negedge mac_rst) begin
    if (!mac_rst) begin
      state        <= S_FILL;
      head_vld     <= '0;
      head_done    <= '0;
      out_valid_q  <= 1'b0;
      out_finish_q <= 1'b0;
      out_index_q  <= '0;
      out_value_q  <= '0;
      count_q      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        head_index[c] <= '0;
        head_value[c] <= '0;
      end
    end else if (bus.restart_i) begin
      state        <= S_FILL;
      head_vld     <= '0;
      head_done    <= '0;
      out_valid_q  <= 1'b0;
      out_finish_q <= 1'b0;
      out_index_q  <= '0;
      out_value_q  <= '0;
      count_q      <= '0;
    end else begin
      // In DRAIN only the end marker matters; data beats are swallowed.
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept[c]) begin
          if (state == S_FILL) begin
            head_vld[c]   <= 1'b1;
            head_done[c]  <= bus.dec_done_i[c];
            head_index[c] <= bus.dec_index_i[c*INDEX_W +: INDEX_W];
            head_value[c] <= bus.dec_value_i[c*VALUE_W +: VALUE_W];
          end else if (bus.dec_done_i[c]) begin
            head_done[c] <= 1'b1;
          end
        end
      end

      case (state)
        S_FILL: begin
          if (&(head_vld | accept)) state <= S_COMPARE;
        end
        S_COMPARE: begin
          if (any_done) begin
            head_vld <= head_vld & head_done;
            state    <= S_DRAIN;
          end else if (all_equal) begin
            out_index_q <= head_index[0];
            out_value_q <= values_packed;
            out_valid_q <= 1'b1;
            state       <= S_EMIT;
          end else begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (head_index[c] < max_index) head_vld[c] <= 1'b0;
            end
            state <= S_FILL;
          end
        end
        S_EMIT: begin
          if (bus.out_ready_i) begin
            head_vld    <= '0;
            out_valid_q <= 1'b0;
            if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
            state <= S_FILL;
          end
        end
        S_DRAIN: begin
          if (&(head_done | (accept & bus.dec_done_i))) begin
            out_finish_q <= 1'b1;
            state        <= S_DONE;
          end
        end
        default: state <= S_DONE;
      endcase
    end
  end

  assign bus.dec_ready_o   = dec_ready;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.out_index_o   = out_index_q;
  assign bus.out_value_o   = out_value_q;
  assign bus.out_finish_o  = out_finish_q;
  assign bus.match_count_o = count_q;

endmodule
